mem_bus_fabric: RTL and testbench
=================================

Name: mem_bus_fabric

Overview:
Parametrised successor to the fixed four-target memory mapper: decodes CPU accesses into NUM_REGIONS address windows, each with a configurable base/mask and a read-only flag.
- Unlike the combinational mapper, it is a registered single-outstanding bus with a req/ready handshake, so each target may insert wait states.
- Reports errors on unmapped addresses, on writes to read-only regions, and on target timeout.
- Sits between the CPU and the bootrom/NVM/MMIO/BRAM targets in the SoC top level.

Parameters:
- NUM_REGIONS, 4, number of target windows.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- REGION_BASE, {32'h8000_0000, 32'h4000_0000, 32'h0010_0000, 32'h0000_0000}, flattened bases; region i at [i*ADDR_W +: ADDR_W].
- REGION_MASK, {32'hFFFE_0000, 32'hFFFF_F000, 32'hFFF0_0000, 32'hFFFF_FC00}, flattened masks; set bits are compared.
- REGION_RO, 4'b0001, per-region read-only flag (bootrom = region 0).
- TIMEOUT_CYCLES, 255, maximum wait cycles in ACCESS before error.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_addr  in  ADDR_W  byte address.
- cpu_be  in  DATA_W/8  byte write enables; all zero means read.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  error flag, qualified by cpu_ready.
- tgt_sel  out  NUM_REGIONS  one-hot target select.
- tgt_addr  out  ADDR_W  region offset, equal to addr & ~mask.
- tgt_be  out  DATA_W/8  byte enables to the target.
- tgt_wdata  out  DATA_W  write data to the target.
- tgt_rdata  in  NUM_REGIONS*DATA_W  flattened target read data.
- tgt_ready  in  NUM_REGIONS  per-target completion.

Behaviour:
- Reset: any clk edge with reset_n=0 forces state IDLE. All outputs go to 0: tgt_sel, tgt_addr, tgt_be, tgt_wdata, cpu_rdata, cpu_ready, cpu_err. The timeout counter clears.
- Reset mid-access drops tgt_sel at that edge and produces no cpu_ready.
- IDLE, when cpu_req=1:
  - Latch addr, be and wdata.
  - Decode hit[i] = ((addr ^ base_i) & mask_i) == 0. The lowest matching index wins.
  - No hit, or a hit on a RO region with be != 0: go to RESP with err=1. tgt_sel is never asserted.
  - Otherwise: go to ACCESS with tgt_sel = onehot(i) and tgt_addr/tgt_be/tgt_wdata driven.
- ACCESS:
  - Outputs are held stable.
  - On tgt_ready[i]=1 for the selected i: capture tgt_rdata slice i into cpu_rdata (also on writes), set err=0, clear tgt_sel, go to RESP.
  - tgt_ready of unselected regions is ignored.
  - Otherwise the counter increments. Reaching TIMEOUT_CYCLES gives err=1, cpu_rdata=0, clear tgt_sel, go to RESP.
- RESP: cpu_ready=1 for exactly one cycle, then IDLE. cpu_req during RESP is ignored.
- cpu_rdata holds its value after RESP until the next capture. cpu_err is 0 outside RESP.
- Latency:
  - Target ready on its first ACCESS cycle gives cpu_ready 2 cycles after the req edge.
  - Each target wait cycle adds 1.
  - Error paths (unmapped or RO write) give cpu_ready 1 cycle after the req edge.
- Counter width is clog2(TIMEOUT_CYCLES+1). It saturates and does not wrap.

Decomposition:
- Package mem_bus_pkg holds:
  - the state enum {IDLE, ACCESS, RESP};
  - the default region base/mask constants;
  - the region index constants (BOOTROM=0, NVM=1, MMIO=2, BRAM=3).
- Sub-module addr_region_decoder: combinational hit vector and priority encoder, returning a valid flag, a one-hot select and the RO bit.

Test Plan:
- Read 0x0000_0010 with tgt_ready[0]=1 in the first ACCESS cycle and tgt_rdata[0]=32'hDEADBEEF -> tgt_sel=4'b0001, tgt_addr=0x10; cpu_ready at +2 with rdata DEADBEEF and err=0.
- Write 0x8000_0104, be=4'b0011, wdata=0x1234ABCD, BRAM ready after 3 waits -> tgt_sel=4'b1000, tgt_addr=0x104, be/wdata stable; cpu_ready at +5 with err=0.
- Write 0x0000_0000, be=4'hF (RO bootrom) -> tgt_sel stays 0; cpu_ready at +1 with err=1.
- Read unmapped 0x2000_0000 -> no tgt_sel; cpu_ready at +1 with err=1. A read of 0x0000_0000 in the same configuration succeeds (RO regions allow reads).
- MMIO read 0x4000_0008 that is never ready, TIMEOUT_CYCLES=4 -> cpu_ready with err=1 and rdata=0 after 4 ACCESS cycles; tgt_sel cleared.
- reset_n=0 during a BRAM access wait -> tgt_sel=0 at that edge, no cpu_ready pulse; a following read of 0x8000_0000 completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and default memory map for the CPU-to-target bus fabric.
// Region order matches the SoC map: bootrom, NVM, MMIO, BRAM.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   localparam int BOOTROM = 0;
   localparam int NVM     = 1;
   localparam int MMIO    = 2;
   localparam int BRAM    = 3;

   localparam int DEF_NUM_REGIONS = 4;
   localparam int DEF_ADDR_W      = 32;

   // Region i lives at bits [i*ADDR_W +: ADDR_W]; the last entry listed is region 0.
   localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_BASE =
      {32'h8000_0000, 32'h4000_0000, 32'h0010_0000, 32'h0000_0000};
   localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_MASK =
      {32'hFFFE_0000, 32'hFFFF_F000, 32'hFFF0_0000, 32'hFFFF_FC00};
   localparam logic [DEF_NUM_REGIONS-1:0] DEF_REGION_RO = 4'b0001;

endpackage

// File: rtl/mem_bus_fabric_addr_region_decoder.sv
// Combinational address decoder: per-region base/mask compare with
// lowest-index priority, producing a one-hot select, RO flag and region offset.
module addr_region_decoder
   import mem_bus_pkg::*;
#(
   parameter int                              NUM_REGIONS = DEF_NUM_REGIONS,
   parameter int                              ADDR_W      = DEF_ADDR_W,
   parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE = DEF_REGION_BASE,
   parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_MASK = DEF_REGION_MASK,
   parameter logic [NUM_REGIONS-1:0]          REGION_RO   = DEF_REGION_RO
) (
   input  logic [ADDR_W-1:0]      addr,
   output logic                   valid,
   output logic [NUM_REGIONS-1:0] sel,
   output logic                   ro,
   output logic [ADDR_W-1:0]      offset
);

   logic [NUM_REGIONS-1:0] hit;

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         hit[i] = ((addr ^ REGION_BASE[i*ADDR_W +: ADDR_W]) & REGION_MASK[i*ADDR_W +: ADDR_W]) == '0;
      end
   end

   // Scan from the top down so the lowest matching index is the last one written.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
      valid  = 1'b0;
      sel    = '0;
      ro     = 1'b0;
      offset = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            valid  = 1'b1;
            sel    = '0;
            sel[i] = 1'b1;
            ro     = REGION_RO[i];
            offset = addr & ~REGION_MASK[i*ADDR_W +: ADDR_W];
         end
      end
   end

endmodule

// File: rtl/mem_bus_fabric.sv
// Registered single-outstanding bus fabric: decodes a CPU access into one of
// NUM_REGIONS targets, waits for its ready with a timeout, and returns a one-cycle response.
module mem_bus_fabric
   import mem_bus_pkg::*;
#(
   parameter int                              NUM_REGIONS    = DEF_NUM_REGIONS,
   parameter int                              ADDR_W         = DEF_ADDR_W,
   parameter int                              DATA_W         = 32,
   parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE    = DEF_REGION_BASE,
   parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_MASK    = DEF_REGION_MASK,
   parameter logic [NUM_REGIONS-1:0]          REGION_RO      = DEF_REGION_RO,
   parameter int                              TIMEOUT_CYCLES = 255
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          cpu_req,
   input  logic [ADDR_W-1:0]             cpu_addr,
   input  logic [DATA_W/8-1:0]           cpu_be,
   input  logic [DATA_W-1:0]             cpu_wdata,
   output logic [DATA_W-1:0]             cpu_rdata,
   output logic                          cpu_ready,
   output logic                          cpu_err,
   output logic [NUM_REGIONS-1:0]        tgt_sel,
   output logic [ADDR_W-1:0]             tgt_addr,
   output logic [DATA_W/8-1:0]           tgt_be,
   output logic [DATA_W-1:0]             tgt_wdata,
   input  logic [NUM_REGIONS*DATA_W-1:0] tgt_rdata,
   input  logic [NUM_REGIONS-1:0]        tgt_ready
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic                   dec_valid;
   logic [NUM_REGIONS-1:0] dec_sel;
   logic                   dec_ro;
   logic [ADDR_W-1:0]      dec_offset;
   logic                   sel_ready;
   logic [DATA_W-1:0]      sel_rdata;

   addr_region_decoder #(
      .NUM_REGIONS (NUM_REGIONS),
      .ADDR_W      (ADDR_W),
      .REGION_BASE (REGION_BASE),
      .REGION_MASK (REGION_MASK),
      .REGION_RO   (REGION_RO)
   ) u_decoder (
      .addr   (cpu_addr),
      .valid  (dec_valid),
      .sel    (dec_sel),
      .ro     (dec_ro),
      .offset (dec_offset)
   );

   // Only the selected target's ready and data are observed.
   assign sel_ready = |(tgt_ready & tgt_sel);

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (tgt_sel[i]) sel_rdata = sel_rdata | tgt_rdata[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         cpu_rdata <= '0;
         cpu_ready <= 1'b0;
         cpu_err   <= 1'b0;
         tgt_sel   <= '0;
         tgt_addr  <= '0;
         tgt_be    <= '0;
         tgt_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  tgt_addr  <= dec_offset;
                  tgt_be    <= cpu_be;
                  tgt_wdata <= cpu_wdata;
                  cnt       <= '0;
                  if (!dec_valid || (dec_ro && (|cpu_be))) begin
                     cpu_err   <= 1'b1;
                     cpu_ready <= 1'b1;
                     state     <= RESP;
                  end else begin
                     tgt_sel <= dec_sel;
                     state   <= ACCESS;
                  end
               end
            end

            ACCESS: begin
               if (sel_ready) begin
                  cpu_rdata <= sel_rdata;
                  cpu_err   <= 1'b0;
                  cpu_ready <= 1'b1;
                  tgt_sel   <= '0;
                  state     <= RESP;
               end else if (cnt == CNT_LAST) begin
                  cpu_rdata <= '0;
                  cpu_err   <= 1'b1;
                  cpu_ready <= 1'b1;
                  tgt_sel   <= '0;
                  state     <= RESP;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            RESP: begin
               cpu_ready <= 1'b0;
               cpu_err   <= 1'b0;
               state     <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Scoreboard bench for mem_bus_fabric: each access pushes its expected response,
// a negedge monitor pops and compares whenever cpu_ready pulses.
module tb_mem_bus_fabric;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         cpu_req = 1'b0;
   logic [31:0]  cpu_addr = '0;
   logic [3:0]   cpu_be = '0;
   logic [31:0]  cpu_wdata = '0;
   logic [31:0]  cpu_rdata;
   logic         cpu_ready;
   logic         cpu_err;
   logic [3:0]   tgt_sel;
   logic [31:0]  tgt_addr;
   logic [3:0]   tgt_be;
   logic [31:0]  tgt_wdata;
   logic [127:0] tgt_rdata = '0;
   logic [3:0]   tgt_ready = '0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      bit          chk_rdata;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mem_bus_fabric #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_be    (cpu_be),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .cpu_err   (cpu_err),
      .tgt_sel   (tgt_sel),
      .tgt_addr  (tgt_addr),
      .tgt_be    (tgt_be),
      .tgt_wdata (tgt_wdata),
      .tgt_rdata (tgt_rdata),
      .tgt_ready (tgt_ready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Response monitor: pops one expectation per cpu_ready pulse.
   always @(negedge clk) begin
      if (cpu_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ready", 64'(cpu_ready), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_err", 64'(cpu_err), 64'(mon_e.err));
            if (mon_e.chk_rdata) check("resp_rdata", 64'(cpu_rdata), 64'(mon_e.rdata));
         end
      end else if (reset_n) begin
         check("err_outside_resp", 64'(cpu_err), 64'd0);
      end
   end

   // region < 0 means no target is expected to be selected; waits < 0 means never ready.
   task automatic access(input string name, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input int region, input int waits,
                         input logic [31:0] rv, input logic exp_err, input bit chk_rdata,
                         input logic [31:0] exp_rdata, input logic [31:0] exp_off,
                         input int exp_lat);
      logic [3:0] oh;
      int         lat;
      exp_t       e;
      oh = (region >= 0) ? 4'(1 << region) : 4'b0000;
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_addr  = addr;
      cpu_be    = be;
      cpu_wdata = wdata;
      tgt_ready = '0;
      tgt_rdata = {32'hFFFF_0003, 32'hFFFF_0002, 32'hFFFF_0001, 32'hFFFF_0000};
      if (region >= 0) tgt_rdata[region*32 +: 32] = rv;
      e.rdata = exp_rdata;
      e.err = exp_err;
      e.chk_rdata = chk_rdata;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      lat = 0;
      for (int k = 0; k < 40; k++) begin
         if (cpu_ready) begin
            lat = k + 1;
            break;
         end
         check({name, "_sel"}, 64'(tgt_sel), 64'(oh));
         if (oh != 4'b0000) begin
            if (k == 0) check({name, "_addr"}, 64'(tgt_addr), 64'(exp_off));
            check({name, "_be"}, 64'(tgt_be), 64'(be));
            check({name, "_wdata"}, 64'(tgt_wdata), 64'(wdata));
         end
         // Unselected targets assert ready while waiting; the fabric must ignore them.
         tgt_ready = (oh != 4'b0000 && k == waits) ? oh : (~oh & 4'hF);
         @(posedge clk);
         #1;
      end
      tgt_ready = '0;
      check({name, "_lat"}, 64'(lat), 64'(exp_lat));
      check({name, "_sel_clr"}, 64'(tgt_sel), 64'd0);
      @(posedge clk);
      #1;
      check({name, "_ready_pulse"}, 64'(cpu_ready), 64'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_sel", 64'(tgt_sel), 64'd0);
      check("rst_addr", 64'(tgt_addr), 64'd0);
      check("rst_be", 64'(tgt_be), 64'd0);
      check("rst_wdata", 64'(tgt_wdata), 64'd0);
      check("rst_rdata", 64'(cpu_rdata), 64'd0);
      check("rst_ready", 64'(cpu_ready), 64'd0);
      check("rst_err", 64'(cpu_err), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      access("boot_rd", 32'h0000_0010, 4'h0, 32'h0, 0, 0, 32'hDEAD_BEEF,
             1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0010, 2);
      access("bram_wr", 32'h8000_0104, 4'b0011, 32'h1234_ABCD, 3, 3, 32'hC0DE_0003,
             1'b0, 1'b1, 32'hC0DE_0003, 32'h0000_0104, 5);
      access("ro_wr", 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, -1, -1, 32'h0,
             1'b1, 1'b0, 32'h0, 32'h0, 1);
      access("unmapped", 32'h2000_0000, 4'h0, 32'h0, -1, -1, 32'h0,
             1'b1, 1'b0, 32'h0, 32'h0, 1);
      access("boot_rd0", 32'h0000_0000, 4'h0, 32'h0, 0, 0, 32'h0BAD_F00D,
             1'b0, 1'b1, 32'h0BAD_F00D, 32'h0000_0000, 2);
      access("mmio_to", 32'h4000_0008, 4'h0, 32'h0, 2, -1, 32'h1111_2222,
             1'b1, 1'b1, 32'h0, 32'h0000_0008, 5);
      access("nvm_rd", 32'h0012_3450, 4'h0, 32'h0, 1, 1, 32'h7777_8888,
             1'b0, 1'b1, 32'h7777_8888, 32'h0002_3450, 3);

      // Reset in the middle of a BRAM wait: select drops, no response appears.
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_addr  = 32'h8000_0040;
      cpu_be    = 4'h0;
      tgt_ready = '0;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      check("rst_mid_sel_pre", 64'(tgt_sel), 64'h8);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_sel", 64'(tgt_sel), 64'd0);
      check("rst_mid_ready", 64'(cpu_ready), 64'd0);
      check("rst_mid_rdata", 64'(cpu_rdata), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mid_no_resp", 64'(cpu_ready), 64'd0);
      check("rst_mid_idle_sel", 64'(tgt_sel), 64'd0);

      access("post_rst_rd", 32'h8000_0000, 4'h0, 32'h0, 3, 0, 32'h5A5A_1234,
             1'b0, 1'b1, 32'h5A5A_1234, 32'h0000_0000, 2);

      repeat (2) @(posedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
